difftest_log_event: RTL and testbench
=====================================

Name: difftest_log_event

Overview:
- Per-event performance-counter observer. Each `PERF(name, cond)` site instantiates one, fed by that site's 32-bit free-running event counter.
- Timestamps the counter and extracts per-cycle increments, including wrap-around.
- Keeps a saturating 64-bit running total.
- Presents snapshot records on a valid/ready dump port, on request or periodically, for the difftest/log back end.

Parameters:
- NAME, "event", string tag identifying the event (reports only, no datapath effect).
- CNT_W, 32, width of the observed counter.
- CORE_W, 8, width of the core/index identifier.
- TS_W, 64, width of timestamp and running total.
- DUMP_INTERVAL, 0, cycles between automatic dumps; 0 disables periodic dumps.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- core_id  in  CORE_W  core/index tag (tied to 0 at PERF sites).
- counter  in  CNT_W  observed event counter.
- dump_req  in  1  one-cycle request for a snapshot record.
- dump_ready  in  1  consumer accepts the record.
- cycle  out  TS_W  cycles elapsed since reset release.
- delta_valid  out  1  counter changed in the previous cycle.
- delta  out  CNT_W  increment observed in the previous cycle.
- total  out  TS_W  saturating sum of all deltas.
- wrap_count  out  16  number of observed counter wraps (saturating).
- dump_valid  out  1  snapshot record available.
- dump_core  out  CORE_W  core_id captured at trigger.
- dump_total  out  TS_W  total captured at trigger.
- dump_cycle  out  TS_W  cycle captured at trigger.

Behaviour:
- Reset: rst low clears asynchronously all state and outputs: cycle, prev sample, delta_valid, delta, total, wrap_count, dump_*, interval timer. Reset mid-operation drops any pending dump.
- cycle: +1 every clk edge with rst high, wrapping modulo 2^TS_W.
- Sampling: prev <= counter every cycle. prev resets to 0, so a counter also reset to 0 yields no spurious delta.
- Delta arithmetic: d = (counter - prev) mod 2^CNT_W.
  - delta_valid <= (counter != prev); delta <= d when changed, else 0. Latency 1 cycle.
- Wrap: wrap_count +1 (saturating at 16'hFFFF) when counter < prev. delta still equals the modular difference, e.g. prev=FFFF_FFFE, counter=1 gives delta 3.
- total: total <= total + zero-extended d, saturating at all-ones and never wrapping. Updated the same cycle as delta.
- Trigger: trigger = dump_req | periodic tick.
  - Periodic tick: when DUMP_INTERVAL != 0, an internal timer counts 0..DUMP_INTERVAL-1 and ticks on reaching DUMP_INTERVAL-1, then restarts at 0.
- Dump handshake:
  - On a trigger, register dump_core=core_id, dump_total=total, dump_cycle=cycle (pre-update values of that cycle), and set dump_valid.
  - dump_valid and payload hold stable until dump_valid & dump_ready.
  - A trigger while dump_valid=1 and dump_ready=0 is dropped; the payload is unchanged.
  - A trigger in the same cycle as a completing handshake loads the new snapshot; dump_valid stays 1.
  - A handshake with no trigger clears dump_valid next cycle.
- dump_ready while dump_valid=0 has no effect.

Optional Feature:
- Macro LOG_EVENT_DISPLAY_EN.
- Defined: on each accepted dump (dump_valid & dump_ready), simulation prints "[%16d] %s core %0d count %0d" with dump_cycle, NAME, dump_core, dump_total. Non-synthesizable code is guarded by the macro.
- Undefined: no print statements; datapath identical.

Test Plan:
- Reset: hold rst low 3 cycles with counter=5 -> all outputs 0; after release, cycle counts 1,2,3 on successive edges.
- Increment: counter 0->1->1->4 on consecutive cycles -> delta_valid 1,0,1 with delta 1,0,3; total ends at 4.
- Wrap: prev=32'hFFFF_FFFE, counter=32'h0000_0001 -> delta=3, wrap_count=1, total increases by 3.
- Dump backpressure: dump_req at cycle 10 with total=7, dump_ready low 4 cycles, second dump_req at cycle 12 -> dump_valid held; payload stays cycle=10, total=7; second request dropped; dump_valid drops after ready.
- Back-to-back: dump_ready=1 and dump_req pulsed on consecutive cycles -> dump_valid stays 1; dump_cycle increments by 1 per record.
- Periodic: DUMP_INTERVAL=4, dump_ready=1, no dump_req -> dump_valid pulses every 4 cycles; dump_cycle values differ by 4.

Source files
------------

// File: rtl/difftest_log_event_if.sv
// Snapshot record port between a perf-event observer and the difftest/log consumer.
// Latency: none, wires only.
// Backpressure: the producer holds dump_valid and the payload until the consumer asserts dump_ready.
// Signals: dump_valid, dump_core, dump_total, dump_cycle (producer to consumer); dump_ready (consumer to producer).
interface difftest_log_event_if #(
    parameter int CORE_W = 8,
    parameter int TS_W   = 64
);
    logic              dump_valid;
    logic              dump_ready;
    logic [CORE_W-1:0] dump_core;
    logic [TS_W-1:0]   dump_total;
    logic [TS_W-1:0]   dump_cycle;

    modport master (
        output dump_valid,
        output dump_core,
        output dump_total,
        output dump_cycle,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_core,
        input  dump_total,
        input  dump_cycle,
        output dump_ready
    );
endinterface

// File: rtl/difftest_log_event.sv
// Per-event perf-counter observer: timestamps a free-running counter and extracts per-cycle deltas,
// wraps and a saturating total. It emits snapshot records on request or periodically.
// Latency: delta/total/wrap_count follow the counter by 1 cycle; a record is valid 1 cycle after its trigger.
// Backpressure: a record is held until dump_ready; triggers while a record is stalled are dropped.
// Ports: clk, rst (async active-low), core_id, counter, dump_req in;
//        cycle, delta_valid, delta, total, wrap_count out; dump (record port, master side).
// Optional: define LOG_EVENT_DISPLAY_EN to print every accepted record in simulation.
module difftest_log_event #(
    parameter string NAME          = "event",
    parameter int    CNT_W         = 32,
    parameter int    CORE_W        = 8,
    parameter int    TS_W          = 64,
    parameter int    DUMP_INTERVAL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CORE_W-1:0]    core_id,
    input  logic [CNT_W-1:0]     counter,
    input  logic                 dump_req,
    output logic [TS_W-1:0]      cycle,
    output logic                 delta_valid,
    output logic [CNT_W-1:0]     delta,
    output logic [TS_W-1:0]      total,
    output logic [15:0]          wrap_count,
    difftest_log_event_if.master dump
);

    logic [CNT_W-1:0] prev;
    logic [CNT_W-1:0] diff;
    logic             changed;
    logic             wrapped;
    logic [TS_W:0]    total_sum;
    logic             tick;
    logic             trigger;
    logic             load;

    // Modular difference gives the true increment across a single counter wrap.
    assign diff      = counter - prev;
    assign changed   = (counter != prev);
    assign wrapped   = (counter < prev);
    // One extra bit catches the carry so the total saturates instead of wrapping.
    assign total_sum = {1'b0, total} + {{(TS_W + 1 - CNT_W){1'b0}}, diff};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle       <= '0;
            prev        <= '0;
            delta_valid <= 1'b0;
            delta       <= '0;
            total       <= '0;
            wrap_count  <= '0;
        end else begin
            cycle       <= cycle + TS_W'(1);
            prev        <= counter;
            delta_valid <= changed;
            delta       <= changed ? diff : '0;
            total       <= total_sum[TS_W] ? '1 : total_sum[TS_W-1:0];
            if (wrapped && (wrap_count != 16'hFFFF)) begin
                wrap_count <= wrap_count + 16'd1;
            end
        end
    end

    generate
        if (DUMP_INTERVAL != 0) begin : g_timer
            localparam int TMR_W = (DUMP_INTERVAL > 1) ? $clog2(DUMP_INTERVAL) : 1;
            localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DUMP_INTERVAL - 1);
            logic [TMR_W-1:0] timer;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    timer <= '0;
                end else if (timer == TMR_LAST) begin
                    timer <= '0;
                end else begin
                    timer <= timer + TMR_W'(1);
                end
            end

            assign tick = (timer == TMR_LAST);
        end else begin : g_no_timer
            assign tick = 1'b0;
        end
    endgenerate

    assign trigger = dump_req | tick;
    // A new snapshot may enter only when the record slot is empty or is being drained this cycle.
    assign load    = trigger & (~dump.dump_valid | dump.dump_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dump.dump_valid <= 1'b0;
            dump.dump_core  <= '0;
            dump.dump_total <= '0;
            dump.dump_cycle <= '0;
        end else if (load) begin
            dump.dump_valid <= 1'b1;
            dump.dump_core  <= core_id;
            dump.dump_total <= total;
            dump.dump_cycle <= cycle;
        end else if (dump.dump_valid && dump.dump_ready) begin
            dump.dump_valid <= 1'b0;
        end
    end

`ifdef LOG_EVENT_DISPLAY_EN
    always @(posedge clk) begin
        if (rst && dump.dump_valid && dump.dump_ready) begin
            $display("[%16d] %s core %0d count %0d",
                     dump.dump_cycle, NAME, dump.dump_core, dump.dump_total);
        end
    end
`endif

endmodule

// File: tb/tb_difftest_log_event.sv
// Bench for difftest_log_event: directed scenarios plus randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: the bench drives dump_ready on the on-demand instance; the periodic instance always accepts.
module tb_difftest_log_event;
    localparam int CNT_W  = 32;
    localparam int CORE_W = 8;
    localparam int TS_W   = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [CORE_W-1:0] core_id = '0;
    logic [CNT_W-1:0]  counter = 32'd5;
    logic              dump_req = 1'b0;
    logic              dump_ready = 1'b0;

    logic [TS_W-1:0]   cycle0, total0, cycle1, total1;
    logic              delta_valid0, delta_valid1;
    logic [CNT_W-1:0]  delta0, delta1;
    logic [15:0]       wrap0, wrap1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    difftest_log_event_if #(.CORE_W(CORE_W), .TS_W(TS_W)) dif0 ();
    difftest_log_event_if #(.CORE_W(CORE_W), .TS_W(TS_W)) dif1 ();

    assign dif0.dump_ready = dump_ready;
    assign dif1.dump_ready = 1'b1;

    difftest_log_event #(.NAME("ev_req"), .CNT_W(CNT_W), .CORE_W(CORE_W), .TS_W(TS_W), .DUMP_INTERVAL(0)) u0 (
        .clk(clk), .rst(rst), .core_id(core_id), .counter(counter), .dump_req(dump_req),
        .cycle(cycle0), .delta_valid(delta_valid0), .delta(delta0), .total(total0),
        .wrap_count(wrap0), .dump(dif0.master)
    );

    difftest_log_event #(.NAME("ev_per"), .CNT_W(CNT_W), .CORE_W(CORE_W), .TS_W(TS_W), .DUMP_INTERVAL(4)) u1 (
        .clk(clk), .rst(rst), .core_id(core_id), .counter(counter), .dump_req(1'b0),
        .cycle(cycle1), .delta_valid(delta_valid1), .delta(delta1), .total(total1),
        .wrap_count(wrap1), .dump(dif1.master)
    );

    always #5 clk = ~clk;

    // Reference model: arithmetic on the counter history plus a one-entry record queue per instance.
    typedef struct packed {
        logic [CORE_W-1:0] core;
        logic [TS_W-1:0]   tot;
        logic [TS_W-1:0]   cyc;
    } rec_t;

    logic [TS_W-1:0]  m_cycle;
    logic [CNT_W-1:0] m_prev;
    logic             m_dv;
    logic [CNT_W-1:0] m_delta;
    logic [TS_W-1:0]  m_total;
    int               m_wraps;
    rec_t             q0[$];
    rec_t             q1[$];
    rec_t             m_snap;
    logic [TS_W:0]    m_sum;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cycle = '0; m_prev = '0; m_dv = 1'b0; m_delta = '0; m_total = '0; m_wraps = 0;
            q0.delete();
            q1.delete();
        end else begin
            m_snap = '{core: core_id, tot: m_total, cyc: m_cycle};
            if (q0.size() != 0 && dump_ready) void'(q0.pop_front());
            if (dump_req && q0.size() == 0) q0.push_back(m_snap);
            if (q1.size() != 0) void'(q1.pop_front());
            if ((m_cycle % 4) == 3 && q1.size() == 0) q1.push_back(m_snap);
            m_dv    = (counter != m_prev);
            m_delta = counter - m_prev;
            if (counter < m_prev && m_wraps < 65535) m_wraps++;
            m_sum   = m_total + m_delta;
            m_total = m_sum[TS_W] ? '1 : m_sum[TS_W-1:0];
            m_prev  = counter;
            m_cycle = m_cycle + 1;
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        chk_cnt++; if (cycle0 !== 64'd0) $display("FAIL reset_cycle: got %0d expected 0", cycle0); else pass_cnt++;
        chk_cnt++; if (delta_valid0 !== 1'b0 || delta0 !== 32'd0) $display("FAIL reset_delta: got %0b/%0h expected 0/0", delta_valid0, delta0); else pass_cnt++;
        chk_cnt++; if (total0 !== 64'd0 || wrap0 !== 16'd0) $display("FAIL reset_total_wrap: got %0h/%0h expected 0/0", total0, wrap0); else pass_cnt++;
        chk_cnt++; if (dif0.dump_valid !== 1'b0 || dif0.dump_total !== 64'd0 || dif0.dump_cycle !== 64'd0 || dif0.dump_core !== 8'd0)
            $display("FAIL reset_dump: got v=%0b t=%0h c=%0h core=%0h expected all 0", dif0.dump_valid, dif0.dump_total, dif0.dump_cycle, dif0.dump_core);
        else pass_cnt++;
        counter = 32'd0;
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk_cnt++; if (cycle0 !== 64'(i)) $display("FAIL reset_count: got %0d expected %0d", cycle0, i); else pass_cnt++;
            chk_cnt++; if (delta_valid0 !== 1'b0) $display("FAIL reset_no_spurious_delta: got %0b expected 0", delta_valid0); else pass_cnt++;
        end
    endtask

    task automatic test_increment();
        logic [CNT_W-1:0] seq [3];
        logic             exp_dv [3];
        logic [CNT_W-1:0] exp_d [3];
        seq = '{32'd1, 32'd1, 32'd4};
        exp_dv = '{1'b1, 1'b0, 1'b1};
        exp_d = '{32'd1, 32'd0, 32'd3};
        for (int i = 0; i < 3; i++) begin
            counter = seq[i];
            @(negedge clk);
            chk_cnt++; if (delta_valid0 !== exp_dv[i] || delta0 !== exp_d[i])
                $display("FAIL incr_step%0d: got dv=%0b d=%0d expected dv=%0b d=%0d", i, delta_valid0, delta0, exp_dv[i], exp_d[i]);
            else pass_cnt++;
        end
        chk_cnt++; if (total0 !== 64'd4) $display("FAIL incr_total: got %0d expected 4", total0); else pass_cnt++;
    endtask

    task automatic test_wrap();
        counter = 32'hFFFF_FFFE;
        @(negedge clk);
        chk_cnt++; if (total0 !== 64'hFFFF_FFFE || wrap0 !== 16'd0)
            $display("FAIL wrap_setup: got total=%0h wraps=%0d expected fffffffe/0", total0, wrap0);
        else pass_cnt++;
        counter = 32'h0000_0001;
        @(negedge clk);
        chk_cnt++; if (delta_valid0 !== 1'b1 || delta0 !== 32'd3) $display("FAIL wrap_delta: got %0b/%0d expected 1/3", delta_valid0, delta0); else pass_cnt++;
        chk_cnt++; if (wrap0 !== 16'd1) $display("FAIL wrap_count: got %0d expected 1", wrap0); else pass_cnt++;
        chk_cnt++; if (total0 !== 64'h1_0000_0001) $display("FAIL wrap_total: got %0h expected 100000001", total0); else pass_cnt++;
    endtask

    task automatic test_dump_backpressure();
        // A pending record must vanish on an asynchronous reset.
        dump_ready = 1'b0;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        chk_cnt++; if (dif0.dump_valid !== 1'b1) $display("FAIL bp_pending: got %0b expected 1", dif0.dump_valid); else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        chk_cnt++; if (dif0.dump_valid !== 1'b0 || cycle0 !== 64'd0)
            $display("FAIL bp_async_reset: got v=%0b cycle=%0d expected 0/0", dif0.dump_valid, cycle0);
        else pass_cnt++;
        @(negedge clk);
        counter = 32'd7;
        core_id = 8'h2A;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk_cnt++; if (cycle0 !== 64'd10 || total0 !== 64'd7) $display("FAIL bp_pre: got cycle=%0d total=%0d expected 10/7", cycle0, total0); else pass_cnt++;
        dump_req = 1'b1;
        for (int c = 11; c <= 15; c++) begin
            @(negedge clk);
            dump_req = (c == 12);
            if (c == 11) counter = 32'd20;
            if (c < 15) begin
                chk_cnt++; if (dif0.dump_valid !== 1'b1 || dif0.dump_cycle !== 64'd10 || dif0.dump_total !== 64'd7 || dif0.dump_core !== 8'h2A)
                    $display("FAIL bp_hold_c%0d: got v=%0b cyc=%0d tot=%0d core=%0h expected 1/10/7/2a", c, dif0.dump_valid, dif0.dump_cycle, dif0.dump_total, dif0.dump_core);
                else pass_cnt++;
            end else begin
                chk_cnt++; if (dif0.dump_valid !== 1'b0) $display("FAIL bp_release: got %0b expected 0", dif0.dump_valid); else pass_cnt++;
            end
            if (c == 14) dump_ready = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        logic [TS_W-1:0] base;
        base = m_cycle;
        dump_ready = 1'b1;
        dump_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_cnt++; if (dif0.dump_valid !== 1'b1 || dif0.dump_cycle !== base + 64'(i))
                $display("FAIL b2b_rec%0d: got v=%0b cyc=%0d expected 1/%0d", i, dif0.dump_valid, dif0.dump_cycle, base + 64'(i));
            else pass_cnt++;
        end
        dump_req = 1'b0;
        @(negedge clk);
        chk_cnt++; if (dif0.dump_valid !== 1'b0) $display("FAIL b2b_drain: got %0b expected 0", dif0.dump_valid); else pass_cnt++;
    endtask

    task automatic test_periodic();
        int              pulses;
        logic [TS_W-1:0] last;
        bit              seen;
        pulses = 0;
        seen = 0;
        last = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk_cnt++; if (dif1.dump_valid !== (q1.size() != 0))
                $display("FAIL per_valid: got %0b expected %0b at cycle %0d", dif1.dump_valid, (q1.size() != 0), m_cycle);
            else pass_cnt++;
            if (q1.size() != 0) begin
                pulses++;
                chk_cnt++; if ((dif1.dump_cycle % 4) !== 64'd3) $display("FAIL per_phase: got cyc=%0d expected cyc mod 4 = 3", dif1.dump_cycle); else pass_cnt++;
                if (seen) begin
                    chk_cnt++; if (dif1.dump_cycle - last !== 64'd4) $display("FAIL per_spacing: got %0d expected 4", dif1.dump_cycle - last); else pass_cnt++;
                end
                last = dif1.dump_cycle;
                seen = 1;
            end
        end
        chk_cnt++; if (pulses != 4) $display("FAIL per_pulses: got %0d expected 4", pulses); else pass_cnt++;
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r >= 3 && r < 8) counter = counter + $urandom_range(1, 1000);
            else if (r == 8) counter = $urandom;
            else if (r == 9) counter = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            dump_req = ($urandom_range(0, 3) == 0);
            dump_ready = ($urandom_range(0, 1) == 1);
            core_id = 8'($urandom);
            @(negedge clk);
            chk_cnt++; if (cycle0 !== m_cycle || delta_valid0 !== m_dv || delta0 !== m_delta)
                $display("FAIL rnd_delta: got cyc=%0d dv=%0b d=%0h expected %0d/%0b/%0h", cycle0, delta_valid0, delta0, m_cycle, m_dv, m_delta);
            else pass_cnt++;
            chk_cnt++; if (total0 !== m_total || wrap0 !== 16'(m_wraps))
                $display("FAIL rnd_total: got tot=%0h wraps=%0d expected %0h/%0d", total0, wrap0, m_total, m_wraps);
            else pass_cnt++;
            chk_cnt++; if (dif0.dump_valid !== (q0.size() != 0)) $display("FAIL rnd_valid: got %0b expected %0b", dif0.dump_valid, (q0.size() != 0)); else pass_cnt++;
            if (q0.size() != 0) begin
                chk_cnt++; if (dif0.dump_core !== q0[0].core || dif0.dump_total !== q0[0].tot || dif0.dump_cycle !== q0[0].cyc)
                    $display("FAIL rnd_payload: got core=%0h tot=%0h cyc=%0d expected %0h/%0h/%0d", dif0.dump_core, dif0.dump_total, dif0.dump_cycle, q0[0].core, q0[0].tot, q0[0].cyc);
                else pass_cnt++;
            end
            if (q1.size() != 0) begin
                chk_cnt++; if (dif1.dump_valid !== 1'b1 || dif1.dump_total !== q1[0].tot || dif1.dump_core !== q1[0].core)
                    $display("FAIL rnd_periodic: got v=%0b tot=%0h core=%0h expected 1/%0h/%0h", dif1.dump_valid, dif1.dump_total, dif1.dump_core, q1[0].tot, q1[0].core);
                else pass_cnt++;
            end
        end
        dump_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_increment();
        test_wrap();
        test_dump_backpressure();
        test_back_to_back();
        test_periodic();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
